// File: rtl/c7blsu_wr_req.sv
// LSU store buffer: in-order FIFO of committed stores, drained one at a time
// through the BIU write arbiter (AW, then W, then wait for B with the LSU write ID).
module c7blsu_wr_req #(
    parameter int          SB_DEPTH = 4,
    parameter logic [3:0]  WR_ID    = 4'h1
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          lsu_st_val,
    output logic                          lsu_st_rdy,
    input  logic [31:0]                   lsu_st_addr,
    input  logic [63:0]                   lsu_st_data,
    input  logic [7:0]                    lsu_st_strb,
    output logic                          lsu_biu_wr_aw_req,
    input  logic                          biu_lsu_wr_aw_ack,
    output logic                          lsu_biu_wr_w_req,
    input  logic                          biu_lsu_wr_w_ack,
    output logic [31:0]                   lsu_biu_wr_addr,
    output logic [63:0]                   lsu_biu_wr_data,
    output logic [7:0]                    lsu_biu_wr_strb,
    output logic                          lsu_biu_wr_last,
    input  logic                          axi_b_valid,
    input  logic [3:0]                    axi_b_id,
    input  logic [1:0]                    axi_b_resp,
    output logic                          lsu_biu_b_ready,
    output logic                          sb_empty,
    output logic [$clog2(SB_DEPTH+1)-1:0] sb_cnt,
    output logic                          wr_err,
    output logic [31:0]                   wr_err_addr,
    input  logic                          wr_err_clr
);

    localparam int PTR_W = $clog2(SB_DEPTH);
    localparam int CNT_W = $clog2(SB_DEPTH+1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_AW   = 2'd1;
    localparam logic [1:0] ST_W    = 2'd2;
    localparam logic [1:0] ST_B    = 2'd3;

    typedef struct packed {
        logic [31:0] addr;
        logic [63:0] data;
        logic [7:0]  strb;
    } sb_entry_t;

    sb_entry_t        mem [SB_DEPTH];
    sb_entry_t        head;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [1:0]       state;
    logic [1:0]       state_nxt;
    logic             push;
    logic             pop;
    logic             b_hit;
    logic             err_new;

    // Ready comes only from the registered count, so a pop never frees a slot same-cycle.
    assign lsu_st_rdy = (sb_cnt != CNT_W'(SB_DEPTH));
    assign push       = lsu_st_val & lsu_st_rdy;
    assign b_hit      = axi_b_valid & (axi_b_id == WR_ID);
    assign pop        = (state == ST_B) & b_hit;
    assign err_new    = pop & (axi_b_resp != 2'b00);
    assign head       = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= '{addr: lsu_st_addr, data: lsu_st_data, strb: lsu_st_strb};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            sb_cnt <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)
                rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   sb_cnt <= sb_cnt + CNT_W'(1);
                2'b01:   sb_cnt <= sb_cnt - CNT_W'(1);
                default: sb_cnt <= sb_cnt;
            endcase
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (sb_cnt != '0)       state_nxt = ST_AW;
            ST_AW:   if (biu_lsu_wr_aw_ack)  state_nxt = ST_W;
            ST_W:    if (biu_lsu_wr_w_ack)   state_nxt = ST_B;
            ST_B:    if (b_hit)              state_nxt = ST_IDLE;
            default:                         state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    // Only the first error since the last clear keeps its address; a clear
    // coinciding with a new error lets the new one re-arm and recapture.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_err      <= 1'b0;
            wr_err_addr <= '0;
        end else if (err_new && (!wr_err || wr_err_clr)) begin
            wr_err      <= 1'b1;
            wr_err_addr <= head.addr;
        end else if (wr_err_clr && !err_new) begin
            wr_err      <= 1'b0;
        end
    end

    assign lsu_biu_wr_aw_req = (state == ST_AW);
    assign lsu_biu_wr_w_req  = (state == ST_W);
    assign lsu_biu_wr_last   = (state == ST_W);
    assign lsu_biu_b_ready   = (state == ST_B);
    assign lsu_biu_wr_addr   = (state != ST_IDLE) ? head.addr : '0;
    assign lsu_biu_wr_data   = (state != ST_IDLE) ? head.data : '0;
    assign lsu_biu_wr_strb   = (state != ST_IDLE) ? head.strb : '0;
    assign sb_empty          = (sb_cnt == '0) && (state == ST_IDLE);

endmodule

// File: tb/tb_c7blsu_wr_req.sv
// Bench for c7blsu_wr_req: queue-based store-buffer model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_c7blsu_wr_req;

    localparam int         SB_DEPTH = 4;
    localparam logic [3:0] WR_ID    = 4'h1;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        st_val = 1'b0;
    logic [31:0] st_addr = '0;
    logic [63:0] st_data = '0;
    logic [7:0]  st_strb = '0;
    logic        aw_ack = 1'b0, w_ack = 1'b0;
    logic        b_valid = 1'b0;
    logic [3:0]  b_id = '0;
    logic [1:0]  b_resp = '0;
    logic        err_clr = 1'b0;

    logic        st_rdy, aw_req, w_req, last, b_ready, sb_empty, wr_err;
    logic [31:0] wr_addr, wr_err_addr;
    logic [63:0] wr_data;
    logic [7:0]  wr_strb;
    logic [2:0]  sb_cnt;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 0;

    always #5 clk = ~clk;

    c7blsu_wr_req #(.SB_DEPTH(SB_DEPTH), .WR_ID(WR_ID)) dut (
        .clk(clk), .reset(rst),
        .lsu_st_val(st_val), .lsu_st_rdy(st_rdy),
        .lsu_st_addr(st_addr), .lsu_st_data(st_data), .lsu_st_strb(st_strb),
        .lsu_biu_wr_aw_req(aw_req), .biu_lsu_wr_aw_ack(aw_ack),
        .lsu_biu_wr_w_req(w_req), .biu_lsu_wr_w_ack(w_ack),
        .lsu_biu_wr_addr(wr_addr), .lsu_biu_wr_data(wr_data),
        .lsu_biu_wr_strb(wr_strb), .lsu_biu_wr_last(last),
        .axi_b_valid(b_valid), .axi_b_id(b_id), .axi_b_resp(b_resp),
        .lsu_biu_b_ready(b_ready), .sb_empty(sb_empty), .sb_cnt(sb_cnt),
        .wr_err(wr_err), .wr_err_addr(wr_err_addr), .wr_err_clr(err_clr)
    );

    // Model: a queue of stores plus which phase the head write is in
    // (0 waiting, 1 address, 2 data, 3 response).
    typedef struct packed {
        logic [31:0] a;
        logic [63:0] d;
        logic [7:0]  s;
    } ent_t;

    ent_t        mq[$];
    int          ph = 0;
    logic        m_err = 1'b0;
    logic [31:0] m_err_addr = '0;

    always @(posedge clk or posedge rst) begin
        bit acc, retire, bad;
        if (rst) begin
            mq.delete();
            ph = 0;
            m_err = 1'b0;
            m_err_addr = '0;
        end else begin
            acc    = st_val && (mq.size() < SB_DEPTH);
            retire = (ph == 3) && b_valid && (b_id == WR_ID);
            bad    = retire && (b_resp != 2'b00);
            if (err_clr) m_err = 1'b0;
            if (bad && !m_err) begin
                m_err = 1'b1;
                m_err_addr = mq[0].a;
            end
            if (ph == 0 && mq.size() != 0) ph = 1;
            else if (ph == 1 && aw_ack)    ph = 2;
            else if (ph == 2 && w_ack)     ph = 3;
            else if (retire)               ph = 0;
            if (retire) void'(mq.pop_front());
            if (acc) mq.push_back('{a: st_addr, d: st_data, s: st_strb});
        end
    end

    always @(negedge clk) begin
        logic [145:0] act, exp;
        ent_t h;
        if (chk_en) begin
            h = (ph != 0) ? mq[0] : '0;
            exp = {mq.size() < SB_DEPTH, ph == 1, ph == 2, ph == 2, ph == 3,
                   mq.size() == 0 && ph == 0, 3'(mq.size()), m_err, m_err_addr,
                   h.a, h.d, h.s};
            act = {st_rdy, aw_req, w_req, last, b_ready, sb_empty, sb_cnt,
                   wr_err, wr_err_addr, wr_addr, wr_data, wr_strb};
            n_tests++;
            if (act !== exp) begin
                n_fail++;
                $display("FAIL cycle_cmp t=%0t got %h expected %h", $time, act, exp);
            end
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        st_val = 0; aw_ack = 0; w_ack = 0; b_valid = 0;
        b_id = WR_ID; b_resp = 0; err_clr = 0;
    endtask

    task automatic push_store(input logic [31:0] a, input logic [63:0] d, input logic [7:0] s);
        st_val = 1; st_addr = a; st_data = d; st_strb = s;
        tick();
        st_val = 0;
    endtask

    function automatic logic sel(input int which);
        case (which)
            0: return aw_req;
            1: return w_req;
            2: return b_ready;
            default: return sb_empty;
        endcase
    endfunction

    task automatic wait_sig(input int which, input string nm);
        int k;
        for (k = 0; k < 60; k++) begin
            if (sel(which)) break;
            tick();
        end
        if (k == 60) begin
            n_tests++;
            n_fail++;
            $display("FAIL timeout_%s: got 0 expected 1", nm);
        end
    endtask

    initial begin
        logic [31:0] sent[$];
        logic [31:0] seen[$];
        idle_in();
        repeat (2) @(posedge clk);
        #1 rst = 0;
        chk_en = 1;
        chk("reset_rdy", st_rdy, 1);
        chk("reset_empty", sb_empty, 1);
        chk("reset_cnt", sb_cnt, 0);
        chk("reset_reqs", {aw_req, w_req, last, b_ready, wr_err}, 0);

        // single store, acks tied high
        aw_ack = 1; w_ack = 1;
        push_store(32'h8000_0010, 64'h1122334455667788, 8'hFF);
        chk("t1_aw_t1", aw_req, 0);
        chk("t1_cnt", sb_cnt, 1);
        tick();
        chk("t1_aw_t2", aw_req, 1);
        chk("t1_addr", wr_addr, 32'h8000_0010);
        tick();
        chk("t1_w_t3", {w_req, last}, 2'b11);
        chk("t1_data", wr_data, 64'h1122334455667788);
        tick();
        chk("t1_bready_t4", b_ready, 1);
        b_valid = 1; b_id = WR_ID; b_resp = 0;
        tick();
        b_valid = 0;
        chk("t1_empty_t5", sb_empty, 1);

        // fill while address phase is stalled
        idle_in();
        for (int i = 0; i < 5; i++) begin
            st_val = 1; st_addr = 32'h1000 + 32'(i * 16);
            st_data = {$urandom, $urandom}; st_strb = 8'h0F;
            if (i < 4) sent.push_back(st_addr);
            tick();
        end
        st_val = 0;
        chk("t2_cnt_full", sb_cnt, 4);
        chk("t2_rdy_full", st_rdy, 0);
        aw_ack = 1; w_ack = 1; b_valid = 1; b_id = WR_ID; b_resp = 0;
        for (int k = 0; k < 40 && !sb_empty; k++) begin
            if (aw_req) seen.push_back(wr_addr);
            tick();
        end
        chk("t2_drained", sb_empty, 1);
        chk("t2_nwrites", seen.size(), 4);
        for (int i = 0; i < 4 && i < seen.size(); i++) chk("t2_order", seen[i], sent[i]);

        // enqueue coincident with pop at count 2
        idle_in(); aw_ack = 1; w_ack = 1;
        push_store(32'h2000, 64'hA, 8'h01);
        push_store(32'h2008, 64'hB, 8'h02);
        wait_sig(2, "t3_bready");
        chk("t3_cnt_pre", sb_cnt, 2);
        st_val = 1; st_addr = 32'h2010; st_data = 64'hC; st_strb = 8'h04;
        b_valid = 1;
        tick();
        st_val = 0; b_valid = 0;
        chk("t3_cnt_same", sb_cnt, 2);
        b_valid = 1;
        wait_sig(3, "t3_drain");
        b_valid = 0;

        // delayed acks: address held 3 cycles, data held 2
        idle_in();
        push_store(32'hA000_0040, 64'h5555, 8'hF0);
        wait_sig(0, "t4_aw");
        for (int i = 0; i < 3; i++) begin
            chk("t4_aw_hold", {aw_req, w_req}, 2'b10);
            chk("t4_addr_hold", wr_addr, 32'hA000_0040);
            tick();
        end
        aw_ack = 1; tick(); aw_ack = 0;
        chk("t4_w_after_aw", {aw_req, w_req}, 2'b01);
        for (int i = 0; i < 2; i++) begin
            chk("t4_w_hold", {aw_req, w_req, last}, 3'b011);
            tick();
        end
        w_ack = 1; tick(); w_ack = 0;
        chk("t4_bready", b_ready, 1);
        chk("t4_addr_b", wr_addr, 32'hA000_0040);
        b_valid = 1; tick(); b_valid = 0;

        // wrong-ID response, then error responses
        idle_in(); aw_ack = 1; w_ack = 1;
        push_store(32'hB000_0008, 64'h1, 8'h01);
        wait_sig(2, "t5_bready");
        b_valid = 1; b_id = 4'h2;
        tick();
        chk("t5_wrong_id", {b_ready, sb_cnt}, {1'b1, 3'd1});
        b_id = WR_ID; b_resp = 2'b10;
        tick();
        b_valid = 0;
        chk("t5_err", wr_err, 1);
        chk("t5_err_addr", wr_err_addr, 32'hB000_0008);
        chk("t5_retired", sb_cnt, 0);
        push_store(32'hC000_0000, 64'h2, 8'h01);
        wait_sig(2, "t5_bready2");
        b_valid = 1; b_resp = 2'b11;
        tick();
        b_valid = 0;
        chk("t5_no_overwrite", wr_err_addr, 32'hB000_0008);
        push_store(32'hD000_0000, 64'h3, 8'h01);
        wait_sig(2, "t5_bready3");
        b_valid = 1; b_resp = 2'b10; err_clr = 1;
        tick();
        b_valid = 0; err_clr = 0;
        chk("t5_clr_vs_err", {wr_err, wr_err_addr}, {1'b1, 32'hD000_0000});
        err_clr = 1; tick(); err_clr = 0;
        chk("t5_cleared", wr_err, 0);

        // reset while in the data phase with 3 entries
        idle_in(); aw_ack = 1;
        push_store(32'hE000_0000, 64'h10, 8'hFF);
        push_store(32'hE000_0008, 64'h11, 8'hFF);
        push_store(32'hE000_0010, 64'h12, 8'hFF);
        wait_sig(1, "t6_w");
        chk("t6_cnt_pre", sb_cnt, 3);
        rst = 1;
        #1;
        chk("t6_rst_reqs", {aw_req, w_req, last, b_ready}, 0);
        chk("t6_rst_bus", {wr_addr, wr_strb}, 0);
        chk("t6_rst_data", wr_data, 0);
        chk("t6_rst_cnt", sb_cnt, 0);
        chk("t6_rst_rdy", {st_rdy, sb_empty}, 2'b11);
        tick();
        rst = 0; aw_ack = 0;
        b_valid = 1; b_id = WR_ID; b_resp = 2'b10;
        tick(); tick();
        b_valid = 0;
        chk("t6_stale_b", {b_ready, wr_err, sb_cnt}, 0);

        // randomized traffic
        for (int c = 0; c < 2000; c++) begin
            st_val  = $urandom_range(0, 1);
            st_addr = $urandom & 32'hFFFF_FFF8;
            st_data = {$urandom, $urandom};
            st_strb = 8'($urandom);
            aw_ack  = ($urandom % 10) < 6;
            w_ack   = ($urandom % 10) < 6;
            b_valid = ($urandom % 10) < 5;
            b_id    = (($urandom % 4) == 0) ? 4'($urandom_range(2, 15)) : WR_ID;
            b_resp  = (($urandom % 8) == 0) ? 2'($urandom) : 2'b00;
            err_clr = ($urandom % 16) == 0;
            rst     = ($urandom % 600) == 0;
            tick();
        end
        idle_in(); rst = 0;
        repeat (3) tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/c7blsu_wr_req.md
Name: c7blsu_wr_req

Overview:
- LSU-side store buffer and write-request sequencer.
- Accepts committed stores from the LSU pipeline into an in-order FIFO.
- Presents the head store to the BIU write arbiter as an AW request, then a W request, using the per-channel req/ack handshake.
- Retires the head entry when the AXI write response (B) for the LSU write ID returns; flags error responses.

Parameters:
SB_DEPTH, 4, store-buffer entries (power of two, >=2)
WR_ID, 4'h1, AXI write ID used by the LSU; must equal the LSU write-ID constant from the AXI types include

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
lsu_st_val  in  1  store valid from LSU pipeline
lsu_st_rdy  out  1  buffer can accept a store
lsu_st_addr  in  32  store address
lsu_st_data  in  64  store data
lsu_st_strb  in  8  byte strobes
lsu_biu_wr_aw_req  out  1  address-phase request to write arbiter
biu_lsu_wr_aw_ack  in  1  address phase accepted
lsu_biu_wr_w_req  out  1  data-phase request to write arbiter
biu_lsu_wr_w_ack  in  1  data phase accepted
lsu_biu_wr_addr  out  32  head address
lsu_biu_wr_data  out  64  head data
lsu_biu_wr_strb  out  8  head strobes
lsu_biu_wr_last  out  1  last beat (single-beat writes)
axi_b_valid  in  1  write response valid
axi_b_id  in  4  write response ID
axi_b_resp  in  2  write response code
lsu_biu_b_ready  out  1  ready for write response
sb_empty  out  1  no buffered or in-flight stores (fence/drain)
sb_cnt  out  $clog2(SB_DEPTH+1)  occupied entries
wr_err  out  1  sticky error-response flag
wr_err_addr  out  32  address of first errored write
wr_err_clr  in  1  clears wr_err

Behaviour:
- Reset (async, active-high):
  - FIFO empty, sb_cnt=0, FSM=IDLE.
  - All req/ready/last outputs 0; addr/data/strb 0; wr_err=0; wr_err_addr=0.
  - lsu_st_rdy=1 and sb_empty=1 once the reset value is applied.
  - Reset mid-transaction discards all entries; no response is awaited after reset.
- Enqueue:
  - Occurs when lsu_st_val & lsu_st_rdy at a rising edge.
  - lsu_st_rdy = (sb_cnt != SB_DEPTH), derived from registered count only; no same-cycle pass-through.
- Dequeue: head entry pops only on B acceptance.
  - Enqueue and pop in the same cycle leave sb_cnt unchanged.
  - Full + pop still reports rdy=0 that cycle.
- Pointers are log2(SB_DEPTH) bits and wrap naturally; count is tracked separately so full and empty are distinct.
- FSM, one write in flight at a time:
  - IDLE: all reqs 0. If sb_cnt!=0, go to AW next cycle.
  - AW: aw_req=1, held until biu_lsu_wr_aw_ack. On ack go to W; aw_req is 0 in the following cycle.
  - W: w_req=1, last=1, held until biu_lsu_wr_w_ack. On ack go to B.
  - B: b_ready=1. On axi_b_valid & axi_b_id==WR_ID: pop head, go to IDLE.
    - A non-matching ID is ignored; stay in B.
- lsu_biu_wr_addr/data/strb carry the head entry, stable, in AW/W/B states; 0 in IDLE.
- Address is passed unmodified; size/burst are set by the arbiter.
- Latency: store enqueued at edge t into an empty buffer gives aw_req high in cycle t+2. Minimum per-store occupancy is 4 cycles (IDLE, AW, W, B) with same-cycle acks.
- Error handling: on an accepted B with resp != 2'b00:
  - If wr_err==0: set wr_err and capture the head address.
  - Later errors do not overwrite the captured address.
  - The entry is still retired; no retry.
  - wr_err_clr clears wr_err; a new error in the same cycle wins (wr_err stays 1, address recaptured).
- sb_empty = (sb_cnt==0) & (FSM==IDLE).

Test Plan:
- Single store addr=0x8000_0010, data=0x1122334455667788, strb=0xFF; acks tied 1; B OKAY one cycle after w_ack -> aw_req at t+2, w_req at t+3 with last=1 and matching addr/data, b_ready at t+4, sb_empty=1 at t+5.
- Fill with 4 stores while aw_ack is held 0 -> sb_cnt=4, lsu_st_rdy=0. 5th store not accepted. Release acks -> 4 writes issued in FIFO order, rdy returns 1 after the first pop.
- Enqueue coincident with pop at sb_cnt=2 -> sb_cnt stays 2; pointer wrap after 9 total stores keeps data order intact.
- aw_ack delayed 3 cycles, w_ack delayed 2 -> aw_req held exactly until ack, never aw_req and w_req both 1, addr stable throughout.
- B with id!=WR_ID, then id==WR_ID with resp=2'b10 -> first ignored, second retires entry; wr_err=1, wr_err_addr=head addr. wr_err_clr together with a new SLVERR -> wr_err stays 1.
- Assert reset in W state with 3 entries -> all outputs 0 immediately, sb_cnt=0, lsu_st_rdy=1, a stale B after reset ignored.
